uftb_update_sched: RTL and testbench

- Scheduler that sequences write updates into the uFTB.
- Two requesters share the single uFTB update port:
  - commit-time training updates, buffered in a FIFO;
  - redirect (mispredict) updates, held in a one-entry priority skid.
- Defers writes while a prediction read fires, with a starvation cap, and coalesces back-to-back commit updates to the same fetch PC.
- Sits between backend update/redirect logic and the uFTB io_update_* inputs.

---
 rtl/uftb_update_sched.sv | 253 +++++++++++++++++++++++++
 tb/tb_uftb_update_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uftb_update_sched.sv
// uFTB write-update scheduler: redirect skid + commit FIFO with coalescing, s0_fire deferral and a starvation cap.
// Optional macro UFTB_UPD_SCHED_PERF_EN adds saturating perf_drop_cnt / perf_coalesce_cnt / perf_force_cnt outputs.
module uftb_update_sched #(
  parameter int PC_W       = 41,
  parameter int DATA_W     = 263,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_enable,
  input  logic              s0_fire,
  input  logic              cmt_valid,
  output logic              cmt_ready,
  input  logic [PC_W-1:0]   cmt_pc,
  input  logic [DATA_W-1:0] cmt_data,
  input  logic              rdr_valid,
  output logic              rdr_ready,
  input  logic [PC_W-1:0]   rdr_pc,
  input  logic [DATA_W-1:0] rdr_data,
  output logic              upd_valid,
  output logic [PC_W-1:0]   upd_pc,
  output logic [DATA_W-1:0] upd_data
`ifdef UFTB_UPD_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_drop_cnt,
  output logic [15:0]       perf_coalesce_cnt,
  output logic [15:0]       perf_force_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [0:0] {ST_DIS = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PC_W-1:0]   r_mem_pc   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic              r_skid_vld;
  logic [PC_W-1:0]   r_skid_pc;
  logic [DATA_W-1:0] r_skid_data;
  logic [SW-1:0]     r_starve;
  logic              r_upd_valid;
  logic [PC_W-1:0]   r_upd_pc;
  logic [DATA_W-1:0] r_upd_data;

  logic              w_empty;
  logic              w_full;
  logic [PW-1:0]     w_count;
  logic [AW-1:0]     w_head_idx;
  logic [AW-1:0]     w_tail_idx;
  logic              w_flush;
  logic              w_cand_vld;
  logic [PC_W-1:0]   w_cand_pc;
  logic [DATA_W-1:0] w_cand_data;
  logic              w_issue;
  logic              w_skid_pop;
  logic              w_fifo_pop;
  logic              w_coal_hit;
  logic              w_coal_wr;
  logic              w_push;
  logic              w_skid_push;
  logic              w_cmt_ready;
  logic              w_rdr_ready;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_count    = r_wptr - r_rptr;
  assign w_head_idx = r_rptr[AW-1:0];
  assign w_tail_idx = r_wptr[AW-1:0] - AW'(1);
  assign w_flush    = (r_state == ST_RUN) && !ctrl_enable;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_DIS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: enable alone selects the mode for the next cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DIS:  w_state_nxt = ctrl_enable ? ST_RUN : ST_DIS;
      ST_RUN:  w_state_nxt = ctrl_enable ? ST_RUN : ST_DIS;
      default: w_state_nxt = ST_DIS;
    endcase
  end

  // Output / datapath control: candidate select, issue, handshakes and coalescing
  always_comb begin
    w_cand_vld  = 1'b0;
    w_cand_pc   = '0;
    w_cand_data = '0;
    w_issue     = 1'b0;
    w_skid_pop  = 1'b0;
    w_fifo_pop  = 1'b0;
    w_coal_hit  = 1'b0;
    w_coal_wr   = 1'b0;
    w_push      = 1'b0;
    w_skid_push = 1'b0;
    w_cmt_ready = 1'b1;
    w_rdr_ready = 1'b1;
    case (r_state)
      ST_RUN: begin
        if (r_skid_vld) begin
          w_cand_vld  = 1'b1;
          w_cand_pc   = r_skid_pc;
          w_cand_data = r_skid_data;
        end else if (!w_empty) begin
          w_cand_vld  = 1'b1;
          w_cand_pc   = r_mem_pc[w_head_idx];
          w_cand_data = r_mem_data[w_head_idx];
        end else begin
          w_cand_vld  = 1'b0;
        end
        w_issue    = w_cand_vld && (!s0_fire || (r_starve == STARVE_LIM));
        w_skid_pop = w_issue && r_skid_vld;
        w_fifo_pop = w_issue && !r_skid_vld;
        // A single-entry FIFO being popped has no stable tail to merge into
        w_coal_hit = !w_empty && (r_mem_pc[w_tail_idx] == cmt_pc)
                     && !(w_fifo_pop && (w_count == PW'(1)));
        w_cmt_ready = !w_full || w_fifo_pop || w_coal_hit;
        w_rdr_ready = !r_skid_vld || w_skid_pop;
        w_push      = cmt_valid && w_cmt_ready && !w_coal_hit;
        w_coal_wr   = cmt_valid && w_coal_hit;
        w_skid_push = rdr_valid && w_rdr_ready;
      end
      default: begin
        w_cmt_ready = 1'b1;
        w_rdr_ready = 1'b1;
      end
    endcase
  end

  // FIFO pointers, redirect skid and starvation counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_pc   <= '0;
      r_skid_data <= '0;
      r_starve    <= '0;
    end else if (w_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_skid_vld  <= 1'b0;
      r_starve    <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_fifo_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      if (w_skid_push) begin
        r_skid_vld  <= 1'b1;
        r_skid_pc   <= rdr_pc;
        r_skid_data <= rdr_data;
      end else if (w_skid_pop) begin
        r_skid_vld  <= 1'b0;
      end else begin
        r_skid_vld  <= r_skid_vld;
      end
      if (w_cand_vld && !w_issue) begin
        r_starve <= (r_starve == STARVE_LIM) ? r_starve : r_starve + SW'(1);
      end else begin
        r_starve <= '0;
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_pc[r_wptr[AW-1:0]]   <= cmt_pc;
      r_mem_data[r_wptr[AW-1:0]] <= cmt_data;
    end else if (w_coal_wr) begin
      r_mem_data[w_tail_idx] <= cmt_data;
    end
  end

  // Registered update port; an issue in the disabling cycle is discarded
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_upd_valid <= 1'b0;
      r_upd_pc    <= '0;
      r_upd_data  <= '0;
    end else if (w_issue && !w_flush) begin
      r_upd_valid <= 1'b1;
      r_upd_pc    <= w_cand_pc;
      r_upd_data  <= w_cand_data;
    end else begin
      r_upd_valid <= 1'b0;
    end
  end

  assign cmt_ready = w_cmt_ready;
  assign rdr_ready = w_rdr_ready;
  assign upd_valid = r_upd_valid;
  assign upd_pc    = r_upd_pc;
  assign upd_data  = r_upd_data;

`ifdef UFTB_UPD_SCHED_PERF_EN
  logic [15:0] r_perf_drop;
  logic [15:0] r_perf_coal;
  logic [15:0] r_perf_force;
  logic [1:0]  w_drop_inc;
  logic [16:0] w_drop_sum;

  assign w_drop_inc = (r_state == ST_DIS) ? ({1'b0, cmt_valid} + {1'b0, rdr_valid}) : 2'd0;
  assign w_drop_sum = {1'b0, r_perf_drop} + {15'd0, w_drop_inc};

  // Saturating performance counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_drop  <= 16'd0;
      r_perf_coal  <= 16'd0;
      r_perf_force <= 16'd0;
    end else begin
      r_perf_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      if (w_coal_wr && (r_perf_coal != 16'hFFFF)) begin
        r_perf_coal <= r_perf_coal + 16'd1;
      end else begin
        r_perf_coal <= r_perf_coal;
      end
      if (w_issue && !w_flush && s0_fire && (r_perf_force != 16'hFFFF)) begin
        r_perf_force <= r_perf_force + 16'd1;
      end else begin
        r_perf_force <= r_perf_force;
      end
    end
  end

  assign perf_drop_cnt     = r_perf_drop;
  assign perf_coalesce_cnt = r_perf_coal;
  assign perf_force_cnt    = r_perf_force;
`endif

endmodule

// File: tb/tb_uftb_update_sched.sv
// Scoreboard bench for uftb_update_sched: expected writes are queued as stimulus is driven
// and popped by a monitor whenever upd_valid is seen.
module tb_uftb_update_sched;
  localparam int PC_W   = 41;
  localparam int DATA_W = 263;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } upd_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              ctrl_enable = 1'b0;
  logic              s0_fire = 1'b0;
  logic              cmt_valid = 1'b0;
  logic              cmt_ready;
  logic [PC_W-1:0]   cmt_pc = '0;
  logic [DATA_W-1:0] cmt_data = '0;
  logic              rdr_valid = 1'b0;
  logic              rdr_ready;
  logic [PC_W-1:0]   rdr_pc = '0;
  logic [DATA_W-1:0] rdr_data = '0;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic [DATA_W-1:0] upd_data;
`ifdef UFTB_UPD_SCHED_PERF_EN
  logic [15:0]       perf_drop_cnt;
  logic [15:0]       perf_coalesce_cnt;
  logic [15:0]       perf_force_cnt;
`endif

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   first_upd_cyc = -1;
  int   t0;
  logic mon_en = 1'b0;
  upd_t sb[$];
  upd_t mon_e;

  uftb_update_sched dut (
    .clock(clock), .reset(reset), .ctrl_enable(ctrl_enable), .s0_fire(s0_fire),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc), .cmt_data(cmt_data),
    .rdr_valid(rdr_valid), .rdr_ready(rdr_ready), .rdr_pc(rdr_pc), .rdr_data(rdr_data),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_data(upd_data)
`ifdef UFTB_UPD_SCHED_PERF_EN
    , .perf_drop_cnt(perf_drop_cnt), .perf_coalesce_cnt(perf_coalesce_cnt),
    .perf_force_cnt(perf_force_cnt)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[DATA_W-1:0];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive one commit for one cycle, checking ready against the expected value
  task automatic cmt_req(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] d, input logic exp_rdy, input string tag);
    cmt_valid = 1'b1; cmt_pc = pc; cmt_data = d;
    @(negedge clock);
    check_eq(tag, DATA_W'(cmt_ready), DATA_W'(exp_rdy));
    step();
    cmt_valid = 1'b0;
  endtask

  task automatic rdr_req(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] d, input logic exp_rdy, input string tag);
    rdr_valid = 1'b1; rdr_pc = pc; rdr_data = d;
    @(negedge clock);
    check_eq(tag, DATA_W'(rdr_ready), DATA_W'(exp_rdy));
    step();
    rdr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clock);
    check_eq(tag, DATA_W'(sb.size()), DATA_W'(0));
    step();
  endtask

  task automatic quiet_window(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_eq(tag, DATA_W'(upd_valid), DATA_W'(1'b0));
    end
    step();
  endtask

  // Monitor: every write strobe must match the oldest expected update
  always @(negedge clock) begin
    if (mon_en && reset && upd_valid) begin
      if (first_upd_cyc < 0) first_upd_cyc = cyc;
      if (sb.size() == 0) begin
        check_eq("unexpected_upd", DATA_W'(upd_valid), DATA_W'(1'b0));
      end else begin
        mon_e = sb.pop_front();
        check_eq("upd_pc", DATA_W'(upd_pc), DATA_W'(mon_e.pc));
        check_eq("upd_data", upd_data, mon_e.data);
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] d, d2;

    #23;
    check_eq("rst_upd_valid", DATA_W'(upd_valid), DATA_W'(1'b0));
    check_eq("rst_upd_pc", DATA_W'(upd_pc), DATA_W'(0));
    check_eq("rst_upd_data", upd_data, DATA_W'(0));
    check_eq("rst_cmt_ready", DATA_W'(cmt_ready), DATA_W'(1'b1));
    check_eq("rst_rdr_ready", DATA_W'(rdr_ready), DATA_W'(1'b1));
    step();
    reset = 1'b1;
    ctrl_enable = 1'b1;
    step();
    step();
    mon_en = 1'b1;

    // Basic latency: handshake in N, strobe in N+2 only
    d = rnd_data();
    sb.push_back('{41'h1000, d});
    cmt_req(41'h1000, d, 1'b1, "s1_cmt_ready");
    @(negedge clock);
    check_eq("s1_lat_n1", DATA_W'(upd_valid), DATA_W'(1'b0));
    @(negedge clock);
    check_eq("s1_lat_n2", DATA_W'(upd_valid), DATA_W'(1'b1));
    @(negedge clock);
    check_eq("s1_pulse_end", DATA_W'(upd_valid), DATA_W'(1'b0));
    step();

    // FIFO fill under s0_fire, backpressure, forced issues in order
    s0_fire = 1'b1;
    first_upd_cyc = -1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      d = rnd_data();
      sb.push_back('{PC_W'(32'h1000 + 32'h20 * i), d});
      cmt_req(PC_W'(32'h1000 + 32'h20 * i), d, 1'b1, "s2_fill_ready");
    end
    cmt_req(41'h1080, rnd_data(), 1'b0, "s2_full_ready");
    wait_drain(200, "s2_drain");
    check_eq("s2_force_latency", DATA_W'(first_upd_cyc - t0), DATA_W'(9));
`ifdef UFTB_UPD_SCHED_PERF_EN
    check_eq("s2_perf_force", DATA_W'(perf_force_cnt), DATA_W'(4));
`endif
    s0_fire = 1'b0;
    step();

    // Coalescing of back-to-back commits to the same PC
    s0_fire = 1'b1;
    d = rnd_data();
    d2 = rnd_data();
    sb.push_back('{41'h2000, d2});
    cmt_req(41'h2000, d, 1'b1, "s3_cmt_a");
    cmt_req(41'h2000, d2, 1'b1, "s3_cmt_b");
    s0_fire = 1'b0;
    wait_drain(20, "s3_drain");
    quiet_window(4, "s3_single_upd");
`ifdef UFTB_UPD_SCHED_PERF_EN
    check_eq("s3_perf_coal", DATA_W'(perf_coalesce_cnt), DATA_W'(1));
`endif

    // Redirect priority over FIFO; skid backpressure
    s0_fire = 1'b1;
    d = rnd_data();
    d2 = rnd_data();
    sb.push_back('{41'h4000, d2});
    sb.push_back('{41'h3000, d});
    cmt_req(41'h3000, d, 1'b1, "s4_cmt");
    rdr_req(41'h4000, d2, 1'b1, "s4_rdr1_ready");
    rdr_req(41'h5000, rnd_data(), 1'b0, "s4_rdr2_ready");
    s0_fire = 1'b0;
    @(negedge clock);
    check_eq("s4_issue_n0", DATA_W'(upd_valid), DATA_W'(1'b0));
    @(negedge clock);
    check_eq("s4_issue_rdr", DATA_W'(upd_valid), DATA_W'(1'b1));
    @(negedge clock);
    check_eq("s4_issue_cmt", DATA_W'(upd_valid), DATA_W'(1'b1));
    step();
    wait_drain(10, "s4_drain");

    // Disable mid-operation flushes queued work; DIS requests are dropped
    s0_fire = 1'b1;
    for (int i = 0; i < 3; i++) cmt_req(PC_W'(32'h5000 + 32'h20 * i), rnd_data(), 1'b1, "s5_fill");
    ctrl_enable = 1'b0;
    step();
    cmt_req(41'h6000, rnd_data(), 1'b1, "s5_dis_ready");
    ctrl_enable = 1'b1;
    s0_fire = 1'b0;
    quiet_window(12, "s5_no_upd");
`ifdef UFTB_UPD_SCHED_PERF_EN
    check_eq("s5_perf_drop", DATA_W'(perf_drop_cnt), DATA_W'(1));
`endif
    d = rnd_data();
    sb.push_back('{41'h5060, d});
    cmt_req(41'h5060, d, 1'b1, "s5_reenable");
    wait_drain(10, "s5_drain");

    // Async reset while a strobe is high
    d = rnd_data();
    sb.push_back('{41'h7000, d});
    cmt_req(41'h7000, d, 1'b1, "s6_cmt_a");
    cmt_req(41'h7020, rnd_data(), 1'b1, "s6_cmt_b");
    @(negedge clock);
    check_eq("s6_pre_valid", DATA_W'(upd_valid), DATA_W'(1'b1));
    #2;
    reset = 1'b0;
    #1;
    check_eq("s6_rst_valid", DATA_W'(upd_valid), DATA_W'(1'b0));
    check_eq("s6_rst_pc", DATA_W'(upd_pc), DATA_W'(0));
    check_eq("s6_rst_data", upd_data, DATA_W'(0));
    check_eq("s6_rst_rdr_ready", DATA_W'(rdr_ready), DATA_W'(1'b1));
`ifdef UFTB_UPD_SCHED_PERF_EN
    check_eq("s6_rst_perf", DATA_W'({perf_drop_cnt, perf_coalesce_cnt, perf_force_cnt}), DATA_W'(0));
`endif
    step();
    reset = 1'b1;
    quiet_window(10, "s6_no_stale");
    check_eq("final_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
